// File: rtl/alu_control_unit_if.sv
// Bus bundle between the ALU control unit and its environment.
//
// Handshake: an instruction transfers on a rising clk edge where
// instr_valid && instr_ready are both 1. instr_ready depends only on the
// control unit's state, never on instr_valid. The environment may change
// instr freely while no transfer happens.
interface alu_control_unit_if #(
    parameter int DW = 32
);
    logic          instr_valid;
    logic [31:0]   instr;
    logic          instr_ready;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [5:0]    alu_op;
    logic          alu_cin;
    logic [DW-1:0] alu_result;
    logic          alu_cout;
    logic          alu_z;
    logic          alu_n;
    logic          done;
    logic          illegal;
    logic          flag_c;
    logic          flag_z;
    logic          flag_n;
    logic [2:0]    dbg_addr;
    logic [DW-1:0] dbg_data;
    logic [1:0]    state_dbg;

    // Control unit side
    modport slave (
        input  instr_valid, instr, alu_result, alu_cout, alu_z, alu_n, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op, alu_cin, done, illegal,
               flag_c, flag_z, flag_n, dbg_data, state_dbg
    );

    // Environment side: instruction source, ALU and debug reader
    modport master (
        output instr_valid, instr, alu_result, alu_cout, alu_z, alu_n, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op, alu_cin, done, illegal,
               flag_c, flag_z, flag_n, dbg_data, state_dbg
    );
endinterface

// File: rtl/alu_control_unit.sv
// ALU control unit: accepts one instruction at a time, reads operands from an
// 8-entry register file, drives an external ALU, and writes back the result
// and status flags. Each instruction takes exactly four cycles:
// IDLE (accept) -> DECODE -> EXEC -> WB.
module alu_control_unit #(
    parameter int DW = 32
) (
    input logic               clk,
    input logic               rst_n,
    alu_control_unit_if.slave bus
);
    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_LDI = 6'b000001;
    localparam logic [5:0] OP_ADD = 6'b010000;
    localparam logic [5:0] OP_SUB = 6'b010001;
    localparam logic [5:0] OP_EQ  = 6'b100000;
    localparam logic [5:0] OP_NE  = 6'b100001;
    localparam logic [5:0] OP_LE  = 6'b100010;
    localparam logic [5:0] OP_GT  = 6'b100011;
    localparam logic [5:0] OP_LLS = 6'b110000;
    localparam logic [5:0] OP_LRS = 6'b110001;
    localparam logic [5:0] OP_ARS = 6'b110010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [5:0]    alu_op_q, alu_op_d;
    logic          alu_cin_q, alu_cin_d;
    logic [DW-1:0] res_q, res_d;
    logic          cout_q, cout_d;
    logic          z_q, z_d;
    logic          n_q, n_d;
    logic [DW-1:0] rf_q [8];
    logic [DW-1:0] rf_d [8];
    logic          flag_c_q, flag_c_d;
    logic          flag_z_q, flag_z_d;
    logic          flag_n_q, flag_n_d;
    logic          done_q, done_d;
    logic          illegal_q, illegal_d;

    logic [5:0]    op;
    logic [2:0]    rd;
    logic [2:0]    rs1;
    logic [2:0]    rs2;
    logic          usec;
    logic [15:0]   imm16;
    logic [DW-1:0] imm_ext;
    logic          op_is_alu;
    logic          op_is_legal;

    // Fields of the instruction held for the whole DECODE..WB window
    assign op    = instr_q[31:26];
    assign rd    = instr_q[25:23];
    assign rs1   = instr_q[22:20];
    assign rs2   = instr_q[19:17];
    assign usec  = instr_q[16];
    assign imm16 = instr_q[15:0];

    // Opcode classification: which ops go through the ALU, which are known
    always_comb begin
        op_is_alu   = (op inside {OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT,
                                  OP_LLS, OP_LRS, OP_ARS});
        op_is_legal = op_is_alu || (op == OP_NOP) || (op == OP_LDI);
        imm_ext     = DW'(imm16);
    end

    // Next-state and datapath logic for the four-phase instruction sequence
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        alu_cin_d = alu_cin_q;
        res_d     = res_q;
        cout_d    = cout_q;
        z_d       = z_q;
        n_d       = n_q;
        rf_d      = rf_q;
        flag_c_d  = flag_c_q;
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            IDLE: begin
                // instr_ready is high here, so valid alone means a transfer
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // The ALU operand outputs double as the latched operand registers
                alu_a_d   = rf_q[rs1];
                alu_b_d   = rf_q[rs2];
                alu_op_d  = op;
                alu_cin_d = usec & flag_c_q;
                state_d   = EXEC;
            end
            EXEC: begin
                res_d     = bus.alu_result;
                cout_d    = bus.alu_cout;
                z_d       = bus.alu_z;
                n_d       = bus.alu_n;
                alu_op_d  = OP_NOP;
                alu_cin_d = 1'b0;
                done_d    = 1'b1;
                illegal_d = !op_is_legal;
                state_d   = WB;
            end
            WB: begin
                if (op_is_alu) begin
                    rf_d[rd] = res_q;
                    flag_z_d = z_q;
                    flag_n_d = n_q;
                    if ((op == OP_ADD) || (op == OP_SUB)) begin
                        flag_c_d = cout_q;
                    end
                end else if (op == OP_LDI) begin
                    rf_d[rd] = imm_ext;
                end
                // r0 is hard-wired to zero
                rf_d[0] = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= OP_NOP;
            alu_cin_q <= 1'b0;
            res_q     <= '0;
            cout_q    <= 1'b0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            alu_cin_q <= alu_cin_d;
            res_q     <= res_d;
            cout_q    <= cout_d;
            z_q       <= z_d;
            n_q       <= n_d;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= rf_d[i];
            end
            flag_c_q  <= flag_c_d;
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_cin     = alu_cin_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.flag_c      = flag_c_q;
    assign bus.flag_z      = flag_z_q;
    assign bus.flag_n      = flag_n_q;
    assign bus.dbg_data    = rf_q[bus.dbg_addr];
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: a behavioural ALU answers the block's requests,
// and an instruction-level model (register array + flags) predicts every
// retire, operand fetch and register value.
module tb_alu_control_unit;
    localparam int DW = 32;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_LDI = 6'b000001;
    localparam logic [5:0] OP_ADD = 6'b010000;
    localparam logic [5:0] OP_SUB = 6'b010001;
    localparam logic [5:0] OP_EQ  = 6'b100000;
    localparam logic [5:0] OP_NE  = 6'b100001;
    localparam logic [5:0] OP_LE  = 6'b100010;
    localparam logic [5:0] OP_GT  = 6'b100011;
    localparam logic [5:0] OP_LLS = 6'b110000;
    localparam logic [5:0] OP_LRS = 6'b110001;
    localparam logic [5:0] OP_ARS = 6'b110010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic clk;
    logic rst_n;

    alu_control_unit_if #(.DW(DW)) bus ();

    alu_control_unit #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural ALU ----------------
    // Returns {carry_or_borrow, result}
    function automatic logic [DW:0] alu_ref(input logic [5:0] o, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic cin);
        logic [DW:0]   r;
        logic [DW-1:0] t;
        r = '0;
        t = '0;
        case (o)
            OP_ADD: r = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
            OP_SUB: r = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, cin};
            OP_EQ:  r = {{DW{1'b0}}, a == b};
            OP_NE:  r = {{DW{1'b0}}, a != b};
            OP_LE:  r = {{DW{1'b0}}, a <= b};
            OP_GT:  r = {{DW{1'b0}}, a > b};
            OP_LLS: begin t = a << b; r = {1'b0, t}; end
            OP_LRS: begin t = a >> b; r = {1'b0, t}; end
            OP_ARS: begin t = $signed(a) >>> b; r = {1'b0, t}; end
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [DW:0] alu_r;
    always_comb begin
        alu_r          = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin);
        bus.alu_result = alu_r[DW-1:0];
        bus.alu_cout   = alu_r[DW];
        bus.alu_z      = (alu_r[DW-1:0] == '0);
        bus.alu_n      = alu_r[DW-1];
    end

    // ---------------- instruction-level model ----------------
    logic [DW-1:0] m_rf [8];
    logic          m_c, m_z, m_n;

    function automatic logic [31:0] enc(input logic [5:0] o, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [2:0] s2,
                                        input logic uc, input logic [15:0] imm);
        return {o, d, s1, s2, uc, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_c = 1'b0;
        m_z = 1'b0;
        m_n = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // done-pulse monitor, sampled on the falling edge
    int cyc_cnt = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (bus.done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            prev_done_cyc <= last_done_cyc;
            last_done_cyc <= cyc_cnt;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic read_reg(input logic [2:0] idx, output logic [DW-1:0] val);
        bus.dbg_addr = idx;
        #1;
        val = bus.dbg_data;
    endtask

    task automatic check_all_regs(input string tag);
        logic [DW-1:0] v;
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v);
            check_eq(tag, 64'(v), 64'(m_rf[i]));
        end
    endtask

    // Issue one instruction from a falling edge and follow it cycle by cycle.
    // hold=1 keeps instr_valid high with junk words while the block is busy.
    task automatic run_instr(input logic [31:0] w, input logic hold);
        logic [5:0]    o;
        logic [2:0]    d, s1, s2;
        logic          uc, cin, legal, is_alu;
        logic [DW-1:0] ea, eb, v;
        logic [DW:0]   r;
        int            waits;
        waits = 0;
        while (bus.instr_ready !== 1'b1 && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        check_eq("ready_before_accept", 64'(bus.instr_ready), 64'd1);
        o      = w[31:26];
        d      = w[25:23];
        s1     = w[22:20];
        s2     = w[19:17];
        uc     = w[16];
        ea     = m_rf[s1];
        eb     = m_rf[s2];
        cin    = uc & m_c;
        is_alu = o inside {OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT, OP_LLS, OP_LRS, OP_ARS};
        legal  = is_alu || o == OP_NOP || o == OP_LDI;
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        @(posedge clk);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            case (cyc)
                1: begin
                    check_eq("decode_ready", 64'(bus.instr_ready), 64'd0);
                    check_eq("decode_done", 64'(bus.done), 64'd0);
                    check_eq("decode_alu_op", 64'(bus.alu_op), 64'd0);
                end
                2: begin
                    check_eq("exec_alu_op", 64'(bus.alu_op), 64'(o));
                    check_eq("exec_alu_a", 64'(bus.alu_a), 64'(ea));
                    check_eq("exec_alu_b", 64'(bus.alu_b), 64'(eb));
                    check_eq("exec_alu_cin", 64'(bus.alu_cin), 64'(cin));
                    check_eq("exec_done", 64'(bus.done), 64'd0);
                end
                3: begin
                    check_eq("wb_done", 64'(bus.done), 64'd1);
                    check_eq("wb_illegal", 64'(bus.illegal), 64'(!legal));
                    check_eq("wb_ready", 64'(bus.instr_ready), 64'd0);
                    check_eq("wb_alu_op", 64'(bus.alu_op), 64'd0);
                    check_eq("wb_alu_a_hold", 64'(bus.alu_a), 64'(ea));
                end
                default: begin
                    if (o == OP_LDI) begin
                        if (d != 3'd0) m_rf[d] = DW'(w[15:0]);
                    end else if (is_alu) begin
                        r = alu_ref(o, ea, eb, cin);
                        if (d != 3'd0) m_rf[d] = r[DW-1:0];
                        m_z = (r[DW-1:0] == '0);
                        m_n = r[DW-1];
                        if (o == OP_ADD || o == OP_SUB) m_c = r[DW];
                    end
                    check_eq("idle_done", 64'(bus.done), 64'd0);
                    check_eq("idle_illegal", 64'(bus.illegal), 64'd0);
                    check_eq("idle_ready", 64'(bus.instr_ready), 64'd1);
                    check_eq("flag_c", 64'(bus.flag_c), 64'(m_c));
                    check_eq("flag_z", 64'(bus.flag_z), 64'(m_z));
                    check_eq("flag_n", 64'(bus.flag_n), 64'(m_n));
                    read_reg(d, v);
                    check_eq("rd_value", 64'(v), 64'(m_rf[d]));
                end
            endcase
            if (cyc < 4) begin
                bus.instr_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
                bus.instr       = $urandom;
            end else begin
                bus.instr_valid = 1'b0;
            end
        end
    endtask

    // Issue ADD and pull reset while it is in EXEC
    task automatic reset_mid_exec(input logic [31:0] w);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_pre_exec_op", 64'(bus.alu_op), 64'(OP_ADD));
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_ready", 64'(bus.instr_ready), 64'd1);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_illegal", 64'(bus.illegal), 64'd0);
        check_eq("rst_alu_a", 64'(bus.alu_a), 64'd0);
        check_eq("rst_alu_b", 64'(bus.alu_b), 64'd0);
        check_eq("rst_alu_op", 64'(bus.alu_op), 64'd0);
        check_eq("rst_alu_cin", 64'(bus.alu_cin), 64'd0);
        check_eq("rst_flags", 64'({bus.flag_c, bus.flag_z, bus.flag_n}), 64'd0);
        check_eq("rst_state", 64'(bus.state_dbg), 64'd0);
        check_all_regs("rst_regs");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_no_done", 64'(bus.done), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_release_ready", 64'(bus.instr_ready), 64'd1);
        check_eq("rst_release_done", 64'(bus.done), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [DW-1:0] v;
    logic [2:0]    sv_flags;
    int            dstart;

    initial begin
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.dbg_addr    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ready", 64'(bus.instr_ready), 64'd1);
        check_eq("reset_done", 64'(bus.done), 64'd0);
        check_eq("reset_alu_op", 64'(bus.alu_op), 64'd0);
        check_eq("reset_alu_a", 64'(bus.alu_a), 64'd0);
        check_eq("reset_flags", 64'({bus.flag_c, bus.flag_z, bus.flag_n}), 64'd0);
        check_all_regs("reset_regs");
        rst_n = 1'b1;
        @(negedge clk);

        // LDI/LDI/ADD back to back
        dstart = done_cnt;
        run_instr(enc(OP_LDI, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0005), 1'b0);
        run_instr(enc(OP_LDI, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0003), 1'b0);
        run_instr(enc(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000), 1'b0);
        read_reg(3'd3, v);
        check_eq("add_r3_eq_8", 64'(v), 64'd8);
        check_eq("add_flags", 64'({bus.flag_c, bus.flag_z, bus.flag_n}), 64'd0);
        check_eq("add_done_count", 64'(done_cnt - dstart), 64'd3);
        check_eq("add_done_spacing", 64'(last_done_cyc - prev_done_cyc), 64'd4);

        // SUB with borrow, then ADD consuming the carry
        run_instr(enc(OP_LDI, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0003), 1'b0);
        run_instr(enc(OP_LDI, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0005), 1'b0);
        run_instr(enc(OP_SUB, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0000), 1'b0);
        read_reg(3'd4, v);
        check_eq("sub_r4", 64'(v), 64'h0000_0000_FFFF_FFFE);
        check_eq("sub_flag_n", 64'(bus.flag_n), 64'd1);
        check_eq("sub_flag_c", 64'(bus.flag_c), 64'd1);
        run_instr(enc(OP_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0000), 1'b0);
        read_reg(3'd5, v);
        check_eq("addc_r5", 64'(v), 64'd1);

        // Unsupported opcode: no write, flags untouched
        sv_flags = {bus.flag_c, bus.flag_z, bus.flag_n};
        run_instr(enc(OP_BAD, 3'd1, 3'd2, 3'd3, 1'b0, 16'hABCD), 1'b0);
        read_reg(3'd1, v);
        check_eq("illegal_r1_kept", 64'(v), 64'd3);
        check_eq("illegal_flags_kept", 64'({bus.flag_c, bus.flag_z, bus.flag_n}), 64'(sv_flags));

        // r0 stays zero; shift left
        run_instr(enc(OP_LDI, 3'd0, 3'd0, 3'd0, 1'b0, 16'hFFFF), 1'b0);
        read_reg(3'd0, v);
        check_eq("r0_zero", 64'(v), 64'd0);
        run_instr(enc(OP_LDI, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0001), 1'b0);
        run_instr(enc(OP_LDI, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0004), 1'b0);
        run_instr(enc(OP_LLS, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0000), 1'b0);
        read_reg(3'd6, v);
        check_eq("lls_r6", 64'(v), 64'h10);
        check_all_regs("directed_regs");

        // instr_valid held high with changing words
        for (int k = 0; k < 6; k++) begin
            run_instr(enc(OP_LDI, 3'(k + 1), 3'd0, 3'd0, 1'b0, 16'($urandom)), 1'b1);
        end

        // Randomized instruction stream
        for (int k = 0; k < 150; k++) begin
            logic [5:0] o;
            int         sel;
            sel = $urandom_range(0, 13);
            case (sel)
                0:       o = OP_NOP;
                1, 2, 3: o = OP_LDI;
                4:       o = OP_ADD;
                5:       o = OP_SUB;
                6:       o = OP_EQ;
                7:       o = OP_NE;
                8:       o = OP_LE;
                9:       o = OP_GT;
                10:      o = OP_LLS;
                11:      o = OP_LRS;
                12:      o = OP_ARS;
                default: o = 6'($urandom);
            endcase
            run_instr(enc(o, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                          16'($urandom)), 1'($urandom_range(0, 3) == 0));
            if (k % 25 == 24) check_all_regs("random_regs");
        end

        // Reset in the middle of ADD r3, then normal operation
        run_instr(enc(OP_LDI, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0005), 1'b0);
        run_instr(enc(OP_LDI, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0003), 1'b0);
        reset_mid_exec(enc(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000));
        read_reg(3'd3, v);
        check_eq("abort_r3_zero", 64'(v), 64'd0);
        run_instr(enc(OP_LDI, 3'd3, 3'd0, 3'd0, 1'b0, 16'h0007), 1'b0);
        read_reg(3'd3, v);
        check_eq("post_reset_r3", 64'(v), 64'd7);
        check_all_regs("final_regs");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "time limit");
    end
endmodule
